// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port synchronous RAM.
//
// Port 0 (core) and port 1 (loader/debug) each present req/we/addr/wdata.
// At most one port is granted per cycle. A granted port may hold the RAM
// across several accesses by asserting its lock input. The lock ends after
// LOCK_MAX consecutive grants.
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_reqN, i_weN, i_lockN      request, write enable, lock request per port
//   i_addrN, i_wdataN           address and write data per port
//   o_ackN                      combinational grant for this cycle
//   o_rvalidN, o_rdataN         read data return, one cycle after a read ack
//   o_ram_load/addr/data        RAM write enable, address, write data
//   i_ram_data                  RAM read data, one cycle after the address
//
// Ownership FSM:
//   state    | meaning
//   ST_FREE  | no owner; grant by request, contested cycles go to the
//            | port that was not granted most recently
//   ST_LOCK0 | port 0 owns the RAM; port 1 held off while port 0 requests
//   ST_LOCK1 | port 1 owns the RAM; port 0 held off while port 1 requests
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic                  i_lock0,
  input  logic                  i_lock1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_ram_load,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             grant0, grant1;

  // Grant selection. In a lock state the owner has priority; if the owner
  // drops its request the lock is over and the other port may take this
  // very cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!i_reset) begin
      case (state_q)
        ST_LOCK0: begin
          if (i_req0)      grant0 = 1'b1;
          else if (i_req1) grant1 = 1'b1;
        end
        ST_LOCK1: begin
          if (i_req1)      grant1 = 1'b1;
          else if (i_req0) grant0 = 1'b1;
        end
        default: begin
          if (i_req0 && i_req1) begin
            if (last_grant_q) grant0 = 1'b1;
            else              grant1 = 1'b1;
          end else begin
            grant0 = i_req0;
            grant1 = i_req1;
          end
        end
      endcase
    end
  end

  // Next-state logic. lock_cnt counts grants in the current lock, including
  // the one from ST_FREE that started it. The grant that brings it to
  // LOCK_MAX ends the lock; last_grant already names the owner at that
  // point, so the other port wins the next contested cycle.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (grant1)      last_grant_d = 1'b1;
    else if (grant0) last_grant_d = 1'b0;
    else             last_grant_d = last_grant_q;

    case (state_q)
      ST_LOCK0: begin
        if (grant0 && i_lock0 && ((lock_cnt_q + CNT_ONE) < CNT_MAX)) begin
          lock_cnt_d = lock_cnt_q + CNT_ONE;
        end else begin
          state_d    = ST_FREE;
          lock_cnt_d = '0;
        end
      end
      ST_LOCK1: begin
        if (grant1 && i_lock1 && ((lock_cnt_q + CNT_ONE) < CNT_MAX)) begin
          lock_cnt_d = lock_cnt_q + CNT_ONE;
        end else begin
          state_d    = ST_FREE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_FREE;
        lock_cnt_d = '0;
        // A single-grant lock limit means a lock can never extend past the
        // grant that requested it, so there is nothing to enter.
        if (LOCK_MAX > 1) begin
          if (grant0 && i_lock0) begin
            state_d    = ST_LOCK0;
            lock_cnt_d = CNT_ONE;
          end else if (grant1 && i_lock1) begin
            state_d    = ST_LOCK1;
            lock_cnt_d = CNT_ONE;
          end
        end
      end
    endcase

    rvalid0_d = grant0 && !i_we0;
    rvalid1_d = grant1 && !i_we1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_FREE;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign o_ack0 = grant0;
  assign o_ack1 = grant1;

  always_comb begin
    o_ram_load = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    if (grant0) begin
      o_ram_load = i_we0;
      o_ram_addr = i_addr0;
      o_ram_data = i_wdata0;
    end else if (grant1) begin
      o_ram_load = i_we1;
      o_ram_addr = i_addr1;
      o_ram_data = i_wdata1;
    end
  end

  // A read granted just before reset asserts would otherwise show up in
  // the first reset cycle; masking with i_reset keeps reset cycles silent.
  assign o_rvalid0 = rvalid0_q && !i_reset;
  assign o_rvalid1 = rvalid1_q && !i_reset;
  assign o_rdata0  = o_rvalid0 ? i_ram_data : '0;
  assign o_rdata1  = o_rvalid1 ? i_ram_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter with LOCK_MAX = 4 and a behavioural RAM.
// Unwritten RAM words read back as 16'hA000 | addr.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        ram_load;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_q;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LOCK_MAX(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_lock0(lock0), .i_lock1(lock1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_ram_load(ram_load), .o_ram_addr(ram_addr), .o_ram_data(ram_wdata),
    .i_ram_data(ram_q)
  );

  logic [15:0] mem [256];
  logic        written [256];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) written[i] <= 1'b0;
    end else if (ram_load) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_q <= written[ram_addr] ? mem[ram_addr] : (16'hA000 | {8'h00, ram_addr});
  end

  typedef struct {
    logic        req0, we0, lock0;
    logic [7:0]  addr0;
    logic [15:0] wdata0;
    logic        req1, we1, lock1;
    logic [7:0]  addr1;
    logic [15:0] wdata1;
    logic        ack0, ack1, load;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;
    logic        rv0, rv1;
    logic [15:0] rd0, rd1;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  vec_t idle;

  // Drive one cycle of inputs just after the rising edge, check at the
  // falling edge.
  task automatic run_vec(input vec_t v, input logic r, input string name);
    logic [60:0] act, exp;
    @(posedge clk);
    #1;
    rst = r;
    req0 = v.req0; we0 = v.we0; lock0 = v.lock0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; we1 = v.we1; lock1 = v.lock1; addr1 = v.addr1; wdata1 = v.wdata1;
    @(negedge clk);
    act = {ack0, ack1, ram_load, ram_addr, ram_wdata, rvalid0, rvalid1, rdata0, rdata1};
    exp = {v.ack0, v.ack1, v.load, v.ram_addr, v.ram_data, v.rv0, v.rv1, v.rd0, v.rd1};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got ack=%b%b load=%b addr=%h data=%h rv=%b%b rd0=%h rd1=%h, want ack=%b%b load=%b addr=%h data=%h rv=%b%b rd0=%h rd1=%h",
               name, ack0, ack1, ram_load, ram_addr, ram_wdata, rvalid0, rvalid1, rdata0, rdata1,
               v.ack0, v.ack1, v.load, v.ram_addr, v.ram_data, v.rv0, v.rv1, v.rd0, v.rd1);
    end
  endtask

  vec_t rdboth, lk, rs;

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    idle = '{0,0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 0,0,0,8'h00,16'h0000, 0,0,16'h0000,16'h0000};

    // idle rows
    for (int i = 0; i < 5; i++) tbl[i] = idle;
    // both ports read every cycle: alternating grants starting with port 0
    tbl[5]  = '{1,0,0,8'h20,16'h0, 1,0,0,8'h30,16'h0, 1,0,0,8'h20,16'h0, 0,0,16'h0000,16'h0000};
    tbl[6]  = '{1,0,0,8'h20,16'h0, 1,0,0,8'h30,16'h0, 0,1,0,8'h30,16'h0, 1,0,16'hA020,16'h0000};
    tbl[7]  = '{1,0,0,8'h20,16'h0, 1,0,0,8'h30,16'h0, 1,0,0,8'h20,16'h0, 0,1,16'h0000,16'hA030};
    tbl[8]  = '{1,0,0,8'h20,16'h0, 1,0,0,8'h30,16'h0, 0,1,0,8'h30,16'h0, 1,0,16'hA020,16'h0000};
    // port 0 write BEEF to 0x10, then read it back
    tbl[9]  = '{1,1,0,8'h10,16'hBEEF, 0,0,0,8'h00,16'h0, 1,0,1,8'h10,16'hBEEF, 0,1,16'h0000,16'hA030};
    tbl[10] = '{1,0,0,8'h10,16'h0, 0,0,0,8'h00,16'h0, 1,0,0,8'h10,16'h0000, 0,0,16'h0000,16'h0000};
    // port 1 locked burst of 3 while port 0 requests continuously
    tbl[11] = '{1,0,0,8'h40,16'h0, 1,0,1,8'h50,16'h0, 0,1,0,8'h50,16'h0000, 1,0,16'hBEEF,16'h0000};
    tbl[12] = '{1,0,0,8'h40,16'h0, 1,0,1,8'h50,16'h0, 0,1,0,8'h50,16'h0000, 0,1,16'h0000,16'hA050};
    tbl[13] = '{1,0,0,8'h40,16'h0, 1,0,0,8'h50,16'h0, 0,1,0,8'h50,16'h0000, 0,1,16'h0000,16'hA050};
    tbl[14] = '{1,0,0,8'h40,16'h0, 1,0,0,8'h50,16'h0, 1,0,0,8'h40,16'h0000, 0,1,16'h0000,16'hA050};
    tbl[15] = idle; tbl[15].rv0 = 1'b1; tbl[15].rd0 = 16'hA040;
    tbl[16] = idle;

    // requests while in reset must not be granted
    rdboth = '{1,0,0,8'h20,16'h0, 1,0,0,8'h30,16'h0, 0,0,0,8'h00,16'h0, 0,0,16'h0,16'h0};
    run_vec(rdboth, 1'b1, "reset_no_grant_a");
    run_vec(rdboth, 1'b1, "reset_no_grant_b");

    for (int i = 0; i < NV; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Lock held by port 1 up to LOCK_MAX=4 with port 0 contending; last
    // grant going in was port 0, so port 1 wins the first cycle.
    lk = '{1,0,0,8'h60,16'h0, 1,0,1,8'h70,16'h0, 0,1,0,8'h70,16'h0, 0,0,16'h0,16'h0};
    run_vec(lk, 1'b0, "lockmax_1");
    lk.rv1 = 1'b1; lk.rd1 = 16'hA070;
    run_vec(lk, 1'b0, "lockmax_2");
    run_vec(lk, 1'b0, "lockmax_3");
    run_vec(lk, 1'b0, "lockmax_4");
    lk.ack0 = 1'b1; lk.ack1 = 1'b0; lk.ram_addr = 8'h60;
    run_vec(lk, 1'b0, "lockmax_release_p0");
    lk.ack0 = 1'b0; lk.ack1 = 1'b1; lk.ram_addr = 8'h70;
    lk.rv0 = 1'b1; lk.rd0 = 16'hA060; lk.rv1 = 1'b0; lk.rd1 = 16'h0;
    run_vec(lk, 1'b0, "lockmax_relock_p1");
    rs = idle; rs.rv1 = 1'b1; rs.rd1 = 16'hA070;
    run_vec(rs, 1'b0, "lock_owner_drops");

    // Port 0 locked read, then reset the very next cycle.
    rs = '{1,0,1,8'h80,16'h0, 0,0,0,8'h00,16'h0, 1,0,0,8'h80,16'h0, 0,0,16'h0,16'h0};
    run_vec(rs, 1'b0, "pre_reset_read");
    rs = '{1,0,0,8'h80,16'h0, 1,0,0,8'h90,16'h0, 0,0,0,8'h00,16'h0, 0,0,16'h0,16'h0};
    run_vec(rs, 1'b1, "in_reset_1");
    run_vec(rs, 1'b1, "in_reset_2");
    run_vec(idle, 1'b0, "post_reset_no_rvalid");
    rs.ack0 = 1'b1; rs.ram_addr = 8'h80;
    run_vec(rs, 1'b0, "post_reset_contest_p0");
    rs = idle; rs.rv0 = 1'b1; rs.rd0 = 16'hA080;
    run_vec(rs, 1'b0, "post_reset_rvalid");
    run_vec(idle, 1'b0, "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
